// File: rtl/priority_resolver_isr.sv
// rtl/priority_resolver_isr.sv - 8259-style priority resolver, in-service register and INTA sequencer
// Rotating priority is built only when ROTATE_PRIORITY_EN is defined; otherwise IR0 is fixed highest.
module priority_resolver_isr #(
    parameter int INTA_TIMEOUT   = 255,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       inta,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    input  logic       auto_eoi,
    output logic       int_out,
    output logic [7:0] clear_IRR,
    output logic       freeze,
    output logic [7:0] in_service_register,
    output logic [2:0] vector_level,
    output logic       vector_valid
);
    typedef enum logic {IDLE = 1'b0, WAIT_ACK2 = 1'b1} state_t;

    localparam logic [7:0] TMO_LAST = 8'(INTA_TIMEOUT - 1);
    localparam logic [2:0] SPUR_LVL = 3'(SPURIOUS_LEVEL);

    state_t     state;
    state_t     state_next;
    logic [2:0] lowest_ptr;
    logic [7:0] pending;
    logic [2:0] req_top;
    logic [2:0] isr_top;
    logic       int_next;
    logic       first_ack;
    logic       second_ack;
    logic       timeout_hit;
    logic       ack_valid;
    logic [7:0] tmo_cnt;
    logic [2:0] ack_level;
    logic       ack_spurious;
    logic [7:0] eoi_clr;
    logic [7:0] auto_clr;
    logic [7:0] set_mask;
    logic [7:0] isr_next;
    logic       eoi_hit;
    logic       auto_hit;
    logic [2:0] eoi_lvl;

    // Scan from the level just above the lowest-priority pointer, wrapping modulo 8.
    function automatic logic [2:0] top_of(input logic [7:0] v, input logic [2:0] lp);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = lp + 3'd1;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = lp + 3'd1 + 3'(i);
            if (v[idx] && !found) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Rank 0 is the highest priority under the current pointer.
    function automatic logic [2:0] rank_of(input logic [2:0] n, input logic [2:0] lp);
        return n - lp - 3'd1;
    endfunction

    assign pending   = interrupt_request_register & ~interrupt_mask;
    assign req_top   = top_of(pending, lowest_ptr);
    assign isr_top   = top_of(in_service_register, lowest_ptr);
    assign int_next  = (pending != 8'd0) &&
                       ((in_service_register == 8'd0) ||
                        (rank_of(req_top, lowest_ptr) < rank_of(isr_top, lowest_ptr)));
    assign ack_valid = int_out && (pending != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (inta) state_next = WAIT_ACK2;
            WAIT_ACK2: if (inta || timeout_hit) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        freeze      = (state == WAIT_ACK2);
        first_ack   = (state == IDLE) && inta;
        second_ack  = (state == WAIT_ACK2) && inta;
        timeout_hit = (state == WAIT_ACK2) && !inta && (tmo_cnt == TMO_LAST);
    end

    // EOI clears land before the new acknowledge bit is set, so a set always survives.
    always_comb begin
        eoi_clr  = 8'd0;
        eoi_hit  = 1'b0;
        eoi_lvl  = 3'd0;
        if (eoi_specific) begin
            if (in_service_register[eoi_level]) begin
                eoi_clr[eoi_level] = 1'b1;
                eoi_hit            = 1'b1;
                eoi_lvl            = eoi_level;
            end
        end else if (eoi_nonspecific && (in_service_register != 8'd0)) begin
            eoi_clr[isr_top] = 1'b1;
            eoi_hit          = 1'b1;
            eoi_lvl          = isr_top;
        end
        auto_hit = second_ack && auto_eoi && !ack_spurious;
        auto_clr = auto_hit ? (8'd1 << ack_level) : 8'd0;
        set_mask = (first_ack && ack_valid) ? (8'd1 << req_top) : 8'd0;
        isr_next = (in_service_register & ~eoi_clr & ~auto_clr) | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_out             <= 1'b0;
            clear_IRR           <= 8'd0;
            in_service_register <= 8'd0;
            vector_level        <= 3'd0;
            vector_valid        <= 1'b0;
            tmo_cnt             <= 8'd0;
            ack_level           <= 3'd0;
            ack_spurious        <= 1'b0;
        end else begin
            int_out             <= int_next;
            clear_IRR           <= set_mask;
            in_service_register <= isr_next;
            vector_valid        <= second_ack;
            if (second_ack) begin
                vector_level <= ack_level;
            end
            if (first_ack) begin
                ack_level    <= ack_valid ? req_top : SPUR_LVL;
                ack_spurious <= !ack_valid;
            end
            if ((state == WAIT_ACK2) && !inta && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end else begin
                tmo_cnt <= 8'd0;
            end
        end
    end

`ifdef ROTATE_PRIORITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lowest_ptr <= 3'd7;
        end else if (rotate_on_eoi && eoi_hit) begin
            lowest_ptr <= eoi_lvl;
        end else if (rotate_on_eoi && auto_hit) begin
            lowest_ptr <= ack_level;
        end
    end
`else
    logic unused_rotate;
    assign unused_rotate = rotate_on_eoi ^ eoi_hit ^ (^eoi_lvl);
    assign lowest_ptr    = 3'd7;
`endif

endmodule

// File: tb/tb_priority_resolver_isr.sv
// tb/tb_priority_resolver_isr.sv - self-checking bench for priority_resolver_isr
module tb_priority_resolver_isr;
    localparam int TMO = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irr = 8'd0;
    logic [7:0] imr = 8'd0;
    logic       inta = 1'b0;
    logic       eoi_nonspecific = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       rotate_on_eoi = 1'b0;
    logic       auto_eoi = 1'b0;
    logic       int_out;
    logic [7:0] clear_IRR;
    logic       freeze;
    logic [7:0] isr;
    logic [2:0] vector_level;
    logic       vector_valid;

    int errors = 0;
    int checks = 0;

    priority_resolver_isr #(.INTA_TIMEOUT(TMO), .SPURIOUS_LEVEL(7)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .interrupt_request_register (irr),
        .interrupt_mask             (imr),
        .inta                       (inta),
        .eoi_nonspecific            (eoi_nonspecific),
        .eoi_specific               (eoi_specific),
        .eoi_level                  (eoi_level),
        .rotate_on_eoi              (rotate_on_eoi),
        .auto_eoi                   (auto_eoi),
        .int_out                    (int_out),
        .clear_IRR                  (clear_IRR),
        .freeze                     (freeze),
        .in_service_register        (isr),
        .vector_level               (vector_level),
        .vector_valid               (vector_valid)
    );

    always #5 clk = ~clk;

    // Reference model: priority as integer rank around the pointer, waiting time as a plain count.
    logic [7:0] m_isr, m_clr, n_isr, n_clr, md_pend;
    logic       m_int, m_wait, m_spur, m_vv, n_int, n_wait, n_spur, n_vv, md_first, md_second;
    logic [2:0] m_lvl, m_vl, n_lvl, n_vl;
    int         m_L, m_cnt, n_L, n_cnt, md_rq, md_it, md_rot;

    function automatic int top_of(input logic [7:0] v, input int l);
        int best;
        best = -1;
        for (int k = 1; k <= 8; k++) begin
            if (best < 0 && v[3'((l + k) % 8)]) best = (l + k) % 8;
        end
        return best;
    endfunction

    function automatic int rank(input int n, input int l);
        return (n - l - 1 + 16) % 8;
    endfunction

    always @* begin
        md_pend   = irr & ~imr;
        md_rq     = top_of(md_pend, m_L);
        md_it     = top_of(m_isr, m_L);
        md_rot    = -1;
        md_first  = inta && !m_wait;
        md_second = inta && m_wait;
        n_int  = (md_pend != 8'd0) && (m_isr == 8'd0 || rank(md_rq, m_L) < rank(md_it, m_L));
        n_isr  = m_isr;
        n_clr  = 8'd0;
        n_L    = m_L;
        n_lvl  = m_lvl;
        n_spur = m_spur;
        n_vl   = m_vl;
        n_vv   = md_second;
        n_wait = m_wait;
        n_cnt  = 0;
        if (eoi_specific) begin
            if (m_isr[eoi_level]) begin
                n_isr[eoi_level] = 1'b0;
                md_rot = int'(eoi_level);
            end
        end else if (eoi_nonspecific && md_it >= 0) begin
            n_isr[3'(md_it)] = 1'b0;
            md_rot = md_it;
        end
        if (md_second && auto_eoi && !m_spur) begin
            n_isr[m_lvl] = 1'b0;
            if (md_rot < 0) md_rot = int'(m_lvl);
        end
        if (md_first) begin
            n_wait = 1'b1;
            if (m_int && md_pend != 8'd0) begin
                n_isr[3'(md_rq)] = 1'b1;
                n_clr[3'(md_rq)] = 1'b1;
                n_lvl  = 3'(md_rq);
                n_spur = 1'b0;
            end else begin
                n_lvl  = 3'd7;
                n_spur = 1'b1;
            end
        end else if (md_second) begin
            n_wait = 1'b0;
            n_vl   = m_lvl;
        end else if (m_wait) begin
            n_cnt = m_cnt + 1;
            if (n_cnt == TMO) begin
                n_wait = 1'b0;
                n_cnt  = 0;
            end
        end
`ifdef ROTATE_PRIORITY_EN
        if (rotate_on_eoi && md_rot >= 0) n_L = md_rot;
`endif
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_isr <= 8'd0; m_clr <= 8'd0; m_L <= 7; m_int <= 1'b0; m_wait <= 1'b0; m_cnt <= 0;
            m_lvl <= 3'd0; m_spur <= 1'b0; m_vl <= 3'd0; m_vv <= 1'b0;
        end else begin
            m_isr <= n_isr; m_clr <= n_clr; m_L <= n_L; m_int <= n_int; m_wait <= n_wait; m_cnt <= n_cnt;
            m_lvl <= n_lvl; m_spur <= n_spur; m_vl <= n_vl; m_vv <= n_vv;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        cyc();
        inta = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b want 0", freeze); end
        rst = 1'b0;
        cyc();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b want 0", int_out); end
        checks++; if (clear_IRR !== 8'h00) begin errors++; $display("FAIL reset_clear_irr: got %h want 00", clear_IRR); end
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h want 00", isr); end
        checks++; if (vector_level !== 3'd0 || vector_valid !== 1'b0) begin errors++; $display("FAIL reset_vector: got %0d/%b want 0/0", vector_level, vector_valid); end
    endtask

    task automatic test_basic_ack();
        irr = 8'h24;
        cyc();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL basic_int_out: got %b want 1", int_out); end
        pulse_inta();
        irr = 8'h20;
        checks++; if (clear_IRR !== 8'h04) begin errors++; $display("FAIL basic_clear_irr: got %h want 04", clear_IRR); end
        checks++; if (isr !== 8'h04) begin errors++; $display("FAIL basic_isr: got %h want 04", isr); end
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL basic_freeze_on: got %b want 1", freeze); end
        cyc();
        checks++; if (clear_IRR !== 8'h00 || freeze !== 1'b1) begin errors++; $display("FAIL basic_clear_pulse: got %h/%b want 00/1", clear_IRR, freeze); end
        pulse_inta();
        checks++; if (vector_valid !== 1'b1 || vector_level !== 3'd2) begin errors++; $display("FAIL basic_vector: got %b/%0d want 1/2", vector_valid, vector_level); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL basic_freeze_off: got %b want 0", freeze); end
        cyc();
        checks++; if (vector_valid !== 1'b0 || vector_level !== 3'd2) begin errors++; $display("FAIL basic_vector_hold: got %b/%0d want 0/2", vector_valid, vector_level); end
    endtask

    task automatic test_hold_off();
        cyc();
        checks++; if (int_out !== 1'b0 || isr !== 8'h04) begin errors++; $display("FAIL hold_lower: got %b/%h want 0/04", int_out, isr); end
        eoi_nonspecific = 1'b1;
        cyc();
        eoi_nonspecific = 1'b0;
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL hold_eoi_isr: got %h want 00", isr); end
        cyc();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL hold_release: got %b want 1", int_out); end
        irr = 8'h00;
        repeat (2) cyc();
    endtask

    task automatic test_eoi_cases();
        irr = 8'h08;
        cyc();
        pulse_inta();
        irr = 8'h00;
        cyc();
        pulse_inta();
        checks++; if (isr !== 8'h08) begin errors++; $display("FAIL eoi_setup_isr: got %h want 08", isr); end
        irr = 8'h02;
        cyc();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL eoi_higher_int: got %b want 1", int_out); end
        inta = 1'b1; eoi_nonspecific = 1'b1;
        cyc();
        inta = 1'b0; eoi_nonspecific = 1'b0; irr = 8'h00;
        checks++; if (isr !== 8'h02 || clear_IRR !== 8'h02) begin errors++; $display("FAIL eoi_with_inta: got %h/%h want 02/02", isr, clear_IRR); end
        cyc();
        pulse_inta();
        checks++; if (vector_level !== 3'd1) begin errors++; $display("FAIL eoi_nested_level: got %0d want 1", vector_level); end
        eoi_specific = 1'b1; eoi_level = 3'd5; eoi_nonspecific = 1'b1;
        cyc();
        eoi_specific = 1'b0; eoi_nonspecific = 1'b0;
        checks++; if (isr !== 8'h02) begin errors++; $display("FAIL eoi_specific_wins: got %h want 02", isr); end
        eoi_specific = 1'b1; eoi_level = 3'd1;
        cyc();
        eoi_specific = 1'b0;
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL eoi_specific_clear: got %h want 00", isr); end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_clr;
        logic [2:0] exp_lvl;
`ifdef ROTATE_PRIORITY_EN
        exp_clr = 8'h10; exp_lvl = 3'd4;
`else
        exp_clr = 8'h01; exp_lvl = 3'd0;
`endif
        rotate_on_eoi = 1'b1;
        irr = 8'h08;
        cyc();
        pulse_inta();
        irr = 8'h00;
        cyc();
        pulse_inta();
        checks++; if (isr !== 8'h08 || vector_level !== 3'd3) begin errors++; $display("FAIL rot_setup: got %h/%0d want 08/3", isr, vector_level); end
        eoi_nonspecific = 1'b1;
        cyc();
        eoi_nonspecific = 1'b0;
        irr = 8'h11;
        cyc();
        pulse_inta();
        irr = 8'h00;
        checks++; if (clear_IRR !== exp_clr) begin errors++; $display("FAIL rot_clear_irr: got %h want %h", clear_IRR, exp_clr); end
        cyc();
        pulse_inta();
        checks++; if (vector_level !== exp_lvl) begin errors++; $display("FAIL rot_level: got %0d want %0d", vector_level, exp_lvl); end
        eoi_nonspecific = 1'b1;
        cyc();
        eoi_nonspecific = 1'b0;
        rotate_on_eoi = 1'b0;
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_cleanup: got %h want 00", isr); end
    endtask

    task automatic test_spurious_timeout();
        logic saw_vv;
        irr = 8'h00;
        repeat (2) cyc();
        pulse_inta();
        checks++; if (freeze !== 1'b1 || isr !== 8'h00 || clear_IRR !== 8'h00) begin errors++; $display("FAIL spur_first: got %b/%h/%h want 1/00/00", freeze, isr, clear_IRR); end
        cyc();
        pulse_inta();
        checks++; if (vector_valid !== 1'b1 || vector_level !== 3'd7 || isr !== 8'h00) begin errors++; $display("FAIL spur_vector: got %b/%0d/%h want 1/7/00", vector_valid, vector_level, isr); end
        irr = 8'h02;
        cyc();
        pulse_inta();
        irr = 8'h00;
        saw_vv = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            cyc();
            if (vector_valid) saw_vv = 1'b1;
        end
        checks++; if (freeze !== 1'b1 || saw_vv !== 1'b0) begin errors++; $display("FAIL tmo_waiting: got freeze=%b vv=%b want 1/0", freeze, saw_vv); end
        cyc();
        checks++; if (freeze !== 1'b0 || vector_valid !== 1'b0 || isr !== 8'h02) begin errors++; $display("FAIL tmo_expire: got %b/%b/%h want 0/0/02", freeze, vector_valid, isr); end
        eoi_specific = 1'b1; eoi_level = 3'd1;
        cyc();
        eoi_specific = 1'b0;
        checks++; if (isr !== 8'h00) begin errors++; $display("FAIL tmo_eoi: got %h want 00", isr); end
    endtask

    task automatic test_auto_eoi_reset();
        auto_eoi = 1'b1;
        irr = 8'h01;
        cyc();
        pulse_inta();
        irr = 8'h00;
        checks++; if (isr !== 8'h01) begin errors++; $display("FAIL aeoi_set: got %h want 01", isr); end
        cyc();
        pulse_inta();
        checks++; if (vector_level !== 3'd0 || vector_valid !== 1'b1 || isr !== 8'h00) begin errors++; $display("FAIL aeoi_clear: got %0d/%b/%h want 0/1/00", vector_level, vector_valid, isr); end
        irr = 8'h01;
        cyc();
        pulse_inta();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL rst_pre_freeze: got %b want 1", freeze); end
        #1 rst = 1'b1;
        #1;
        checks++; if (freeze !== 1'b0 || isr !== 8'h00 || int_out !== 1'b0) begin errors++; $display("FAIL rst_async: got %b/%h/%b want 0/00/0", freeze, isr, int_out); end
        cyc();
        rst = 1'b0; auto_eoi = 1'b0; irr = 8'h00;
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            irr             = 8'($urandom);
            imr             = 8'($urandom & $urandom);
            inta            = ($urandom_range(0, 2) == 0);
            eoi_nonspecific = ($urandom_range(0, 7) == 0);
            eoi_specific    = ($urandom_range(0, 7) == 0);
            eoi_level       = 3'($urandom_range(0, 7));
            rotate_on_eoi   = 1'($urandom_range(0, 1));
            if (i % 64 == 0) auto_eoi = 1'($urandom_range(0, 1));
            cyc();
            checks++; if (int_out !== m_int) begin errors++; $display("FAIL rnd_int_out @%0d: got %b want %b", i, int_out, m_int); end
            checks++; if (clear_IRR !== m_clr) begin errors++; $display("FAIL rnd_clear_irr @%0d: got %h want %h", i, clear_IRR, m_clr); end
            checks++; if (freeze !== m_wait) begin errors++; $display("FAIL rnd_freeze @%0d: got %b want %b", i, freeze, m_wait); end
            checks++; if (isr !== m_isr) begin errors++; $display("FAIL rnd_isr @%0d: got %h want %h", i, isr, m_isr); end
            checks++; if (vector_valid !== m_vv) begin errors++; $display("FAIL rnd_vector_valid @%0d: got %b want %b", i, vector_valid, m_vv); end
            checks++; if (vector_level !== m_vl) begin errors++; $display("FAIL rnd_vector_level @%0d: got %0d want %0d", i, vector_level, m_vl); end
        end
        inta = 1'b0; eoi_nonspecific = 1'b0; eoi_specific = 1'b0; irr = 8'h00; imr = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_hold_off();
        test_eoi_cases();
        test_rotation();
        test_spurious_timeout();
        test_auto_eoi_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/priority_resolver_isr.md
Name: priority_resolver_isr

Overview:
Downstream stage of the interrupt request register in the 8259-style PIC. Resolves the highest-priority unmasked pending request, drives the CPU interrupt line, and runs the two-pulse INTA acknowledge sequence. Maintains the in-service register (ISR) and handles EOI commands. Feeds clear_IRR and freeze back to the request register.

Parameters:
INTA_TIMEOUT, 255, cycles spent in WAIT_ACK2 without a second INTA before aborting the sequence; 8-bit counter.
SPURIOUS_LEVEL, 7, level reported when the first INTA finds no valid request.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, asynchronous and active-high
interrupt_request_register  input  8  pending requests from the IRR
interrupt_mask  input  8  IMR; 1 = masked
inta  input  1  one-cycle strobe per CPU INTA pulse (already synchronised)
eoi_nonspecific  input  1  one-cycle strobe: clear the highest-priority ISR bit
eoi_specific  input  1  one-cycle strobe: clear ISR bit eoi_level
eoi_level  input  3  target of a specific EOI
rotate_on_eoi  input  1  config: rotate priority when an ISR bit is cleared
auto_eoi  input  1  config: clear the ISR bit at the second INTA
int_out  output  1  interrupt request to CPU
clear_IRR  output  8  one-hot, one-cycle clear pulse to the IRR
freeze  output  1  holds the IRR during the acknowledge sequence
in_service_register  output  8  current ISR
vector_level  output  3  acknowledged level; held until the next sequence
vector_valid  output  1  one-cycle strobe: vector_level is valid

Behaviour:
- Reset (asynchronous): int_out=0, clear_IRR=0, freeze=0, ISR=0, vector_level=0, vector_valid=0, lowest-priority pointer L=7, state=IDLE, timeout counter=0. Asserting reset mid-sequence aborts to IDLE immediately.
- Priority order: highest priority is (L+1) mod 8, then descending modulo 8. L=7 gives IR0 highest.
- Pending set P = IRR & ~IMR. req_top = highest-priority bit of P. isr_top = highest-priority bit of ISR.
- int_out is registered with 1-cycle latency. It is 1 when P is non-zero and either ISR=0 or req_top is strictly higher priority than isr_top. An equal or lower request is held off.
- FSM has two states, IDLE and WAIT_ACK2.
- IDLE + inta:
  - If int_out=1: set ISR[req_top]; clear_IRR = one-hot(req_top) for exactly 1 cycle; latch the level.
  - If int_out=0: spurious. Latch SPURIOUS_LEVEL; ISR and clear_IRR unchanged.
  - In both cases, freeze=1 from the next cycle and the FSM goes to WAIT_ACK2.
- WAIT_ACK2 + inta:
  - vector_level = latched level and vector_valid=1 for 1 cycle.
  - If auto_eoi=1 and the sequence was not spurious, clear that ISR bit (rotation applies as for EOI).
  - freeze=0 and the FSM returns to IDLE next cycle.
- WAIT_ACK2 with no inta for INTA_TIMEOUT cycles: return to IDLE with freeze=0, no vector_valid, and the ISR bit kept.
- Non-specific EOI clears isr_top; no effect when ISR=0. Specific EOI clears ISR[eoi_level]; no effect if that bit is already 0.
- If both EOI strobes arrive in the same cycle, the specific EOI wins.
- Rotation: when an EOI or auto-EOI clears bit n and rotate_on_eoi=1, L<=n.
- EOI and a first inta in the same cycle: int_out and req_top use pre-EOI state; the EOI clear is applied first, then the new ISR bit is set. If the EOI targets the bit being set, the bit ends up set.
- inta in IDLE never produces vector_valid.

Optional Feature:
ROTATE_PRIORITY_EN.
- Defined: rotation behaves as described above.
- Undefined: L is a constant 7 (fixed priority, IR0 highest), rotate_on_eoi is ignored, and the rotation logic is not synthesised.

Test Plan:
- Reset, IRR=8'h00 -> all outputs 0. Then IRR=8'h24, IMR=0 -> int_out=1 one cycle later.
- IRR=8'h24, inta, inta -> clear_IRR=8'h04 for 1 cycle; ISR=8'h04; freeze high between the INTAs; vector_level=2 with a vector_valid pulse.
- ISR=8'h04, IRR=8'h20 -> int_out stays 0. Non-specific EOI -> ISR=0, then int_out=1.
- Rotation (ROTATE_PRIORITY_EN defined), rotate_on_eoi=1, ISR=8'h08, non-specific EOI -> L=3. Then IRR=8'h11 -> acknowledged level 4.
- inta with IRR=0 -> vector_level=7, ISR and clear_IRR unchanged. Also: a single inta with no follow-up -> freeze drops after 255 cycles with no vector_valid.
- auto_eoi=1, IRR=8'h01, inta, inta -> vector_level=0 and ISR returns to 0 after the second inta. Also: rst asserted in WAIT_ACK2 -> freeze=0 immediately.
